// File: rtl/mu0_mem_loader_if.sv
// Loader, MU0-side and memory-side signals of the boot sequencer, bundled as one port.
// The slave modport is the sequencer view; master is the surrounding system / bench view.
interface mu0_mem_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_memrq;
  logic              cpu_rnw;
  logic              cpu_rst_n;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_in_data;
  logic              mem_memrq;
  logic              mem_rw;
  logic              mem_rst_n;

  logic [CNT_W-1:0]  word_count;
  logic              ovf;
  logic              done;

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last,
    input  cpu_addr, cpu_data, cpu_memrq, cpu_rnw,
    output ld_ready, cpu_rst_n,
    output mem_addr, mem_in_data, mem_memrq, mem_rw, mem_rst_n,
    output word_count, ovf, done
  );

  modport master (
    output ld_start, ld_valid, ld_data, ld_last,
    output cpu_addr, cpu_data, cpu_memrq, cpu_rnw,
    input  ld_ready, cpu_rst_n,
    input  mem_addr, mem_in_data, mem_memrq, mem_rw, mem_rst_n,
    input  word_count, ovf, done
  );
endinterface

// File: rtl/mu0_mem_loader.sv
// Boot sequencer: clears memory, streams a loader image from address 0, then releases MU0 and hands it the bus.
// Latency: loader writes and RUN pass-through are combinational onto the memory bus; cpu_rst_n/mem_rst_n registered.
// Backpressure: ld_ready only in LOAD; loader may stall indefinitely with ld_valid=0.
module mu0_mem_loader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 32,
  parameter int CLR_CYCLES = 2,
  parameter int RST_HOLD   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mu0_mem_loader_if.slave  bus
);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int HOLD_MAX = (CLR_CYCLES > RST_HOLD) ? CLR_CYCLES : RST_HOLD;
  localparam int CYC_W    = $clog2(HOLD_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              cpu_rst_n_q;
  logic              mem_rst_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      mem_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      // Both resets are driven from the next state so they change on the same edge as the state.
      cpu_rst_n_q <= (state_d == S_RUN);
      mem_rst_n_q <= (state_d != S_CLEAR);
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.ld_start) begin
          state_d = S_CLEAR;
          cyc_d   = '0;
          ptr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        if (cyc_q == CYC_W'(CLR_CYCLES - 1)) begin
          state_d = S_LOAD;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.ld_valid) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (bus.ld_last) begin
            state_d = S_RELEASE;
            cyc_d   = '0;
          end
          // Last physical word: stop regardless, flag a truncated image.
          if (ptr_q == PTR_W'(DEPTH - 1)) begin
            state_d = S_RELEASE;
            cyc_d   = '0;
            ovf_d   = ~bus.ld_last;
          end
        end
      end
      S_RELEASE: begin
        if (cyc_q == CYC_W'(RST_HOLD - 1)) begin
          state_d = S_RUN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_in_data = '0;
    bus.mem_memrq   = 1'b0;
    bus.mem_rw      = 1'b1;
    case (state_q)
      S_LOAD: begin
        bus.mem_addr    = {{(ADDR_W - PTR_W){1'b0}}, ptr_q};
        bus.mem_in_data = bus.ld_data;
        bus.mem_memrq   = bus.ld_valid;
        bus.mem_rw      = 1'b0;
      end
      S_RUN: begin
        bus.mem_addr    = bus.cpu_addr;
        bus.mem_in_data = bus.cpu_data;
        bus.mem_memrq   = bus.cpu_memrq;
        bus.mem_rw      = bus.cpu_rnw;
      end
      default: ;
    endcase
  end

  assign bus.ld_ready   = (state_q == S_LOAD);
  assign bus.done       = (state_q == S_RUN);
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.mem_rst_n  = mem_rst_n_q;
  assign bus.word_count = cnt_q;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_mu0_mem_loader.sv
// Randomised bench for mu0_mem_loader: scoreboarded loader writes, behavioural memory, phase-length and pass-through checks.
module tb_mu0_mem_loader;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int DEPTH      = 32;
  localparam int CLR_CYCLES = 2;
  localparam int RST_HOLD   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mu0_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  mu0_mem_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .CLR_CYCLES(CLR_CYCLES), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] mem_model[DEPTH];
  logic [15:0] image[DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural stand-in for memory_32x16: synchronous clear and write.
  always @(posedge clk) begin
    if (bus.mem_rst_n === 1'b0) begin
      for (int i = 0; i < DEPTH; i++) mem_model[i] <= '0;
    end else if (bus.mem_memrq === 1'b1 && bus.mem_rw === 1'b0 && bus.mem_addr < DEPTH) begin
      mem_model[bus.mem_addr[4:0]] <= bus.mem_in_data;
    end
  end

  // Monitor: pops expected loader writes; outside LOAD/RUN the bus must sit idle.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.ld_ready === 1'b1) begin
          if (bus.mem_memrq === 1'b1) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.mem_addr, bus.mem_in_data);
            end else begin
              e = exp_q.pop_front();
              chk("wr_addr", 32'(bus.mem_addr), e.addr);
              chk("wr_data", 32'(bus.mem_in_data), 32'(e.data));
              chk("wr_rw", 32'(bus.mem_rw), 0);
            end
          end
        end else if (bus.done !== 1'b1) begin
          chk("idle_bus", 32'({bus.mem_memrq, bus.mem_rw, bus.mem_addr, bus.mem_in_data}),
              32'({1'b0, 1'b1, 12'h000, 16'h0000}));
        end
      end
    end
  end

  task automatic drive_cpu_random();
    bus.cpu_addr  = 12'($urandom);
    bus.cpu_data  = 16'($urandom);
    bus.cpu_memrq = 1'($urandom_range(0, 1));
    bus.cpu_rnw   = 1'($urandom_range(0, 1));
  endtask

  task automatic do_load(input int n, input bit last, input int stall_pct);
    int  cnt;
    int  exp_wc;
    bit  exp_ovf;
    bit  was_run;
    logic [15:0] d;
    if (!last) n = DEPTH;
    exp_wc  = n;
    exp_ovf = !last;
    was_run = (bus.done === 1'b1);
    bus.ld_start = 1'b1;
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    if (was_run) begin
      chk("reload_cpu_rst_n", 32'(bus.cpu_rst_n), 0);
      chk("reload_done", 32'(bus.done), 0);
      chk("reload_memrq", 32'(bus.mem_memrq), 0);
    end
    cnt = 0;
    for (int k = 0; k < 10 && bus.ld_ready !== 1'b1; k++) begin
      drive_cpu_random();
      @(negedge clk);
      if (bus.mem_rst_n === 1'b0) cnt++;
    end
    chk("clear_to_load", 32'(bus.ld_ready), 1);
    chk("clear_cycles", cnt, CLR_CYCLES);
    chk("entry_word_count", 32'(bus.word_count), 0);
    chk("entry_ovf", 32'(bus.ovf), 0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < stall_pct) begin
        bus.ld_valid = 1'b0;
        bus.ld_start = 1'($urandom_range(0, 1));
        bus.ld_data  = 16'($urandom);
        drive_cpu_random();
        @(posedge clk); #1;
      end
      bus.ld_start = 1'b0;
      d = 16'($urandom);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last && (i == n - 1);
      image[i] = d;
      exp_q.push_back('{i, d});
      drive_cpu_random();
      @(posedge clk); #1;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10 && bus.done !== 1'b1; k++) begin
      bus.ld_valid = 1'($urandom_range(0, 1));
      drive_cpu_random();
      @(negedge clk);
      if (bus.cpu_rst_n === 1'b0) cnt++;
    end
    bus.ld_valid  = 1'b0;
    bus.cpu_memrq = 1'b0;
    chk("release_to_run", 32'(bus.done), 1);
    chk("release_cycles", cnt, RST_HOLD);
    chk("run_cpu_rst_n", 32'(bus.cpu_rst_n), 1);
    chk("word_count", 32'(bus.word_count), exp_wc);
    chk("ovf", 32'(bus.ovf), 32'(exp_ovf));
    for (int j = 0; j < DEPTH; j++)
      chk($sformatf("mem[%0d]", j), 32'(mem_model[j]), (j < exp_wc) ? 32'(image[j]) : 0);
  endtask

  task automatic pass_through(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      drive_cpu_random();
      bus.ld_valid = 1'($urandom_range(0, 1));
      #1;
      chk("pt_bus", 32'({bus.mem_addr, bus.mem_in_data, bus.mem_memrq, bus.mem_rw}),
          32'({bus.cpu_addr, bus.cpu_data, bus.cpu_memrq, bus.cpu_rnw}));
      chk("pt_done", 32'(bus.done), 1);
    end
    bus.ld_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_cpu_rst_n"}, 32'(bus.cpu_rst_n), 0);
    chk({tag, "_mem_rst_n"}, 32'(bus.mem_rst_n), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_memrq"}, 32'(bus.mem_memrq), 0);
    chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 0);
    chk({tag, "_word_count"}, 32'(bus.word_count), 0);
    chk({tag, "_ovf"}, 32'(bus.ovf), 0);
  endtask

  initial begin
    int n;
    bit last;
    rst_n         = 1'b0;
    bus.ld_start  = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.ld_last   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_data  = '0;
    bus.cpu_memrq = 1'b0;
    bus.cpu_rnw   = 1'b1;
    #1;
    reset_checks("por");
    chk("por_mem_rw", 32'(bus.mem_rw), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_mem_rst_n", 32'(bus.mem_rst_n), 1);
    chk("idle_cpu_rst_n", 32'(bus.cpu_rst_n), 0);
    chk("idle_ld_ready", 32'(bus.ld_ready), 0);

    do_load(21, 1'b1, 30);
    pass_through(20);

    // Reload from RUN while the core is mid-access.
    bus.cpu_memrq = 1'b1;
    do_load(5, 1'b1, 20);
    do_load(2, 1'b1, 60);
    do_load(DEPTH, 1'b0, 10);
    do_load(DEPTH, 1'b1, 10);
    pass_through(8);

    repeat (4) begin
      n    = $urandom_range(1, DEPTH);
      last = ($urandom_range(0, 3) != 0);
      do_load(n, last, 25);
      pass_through(4);
    end

    // Asynchronous reset in RUN, checked before any clock edge.
    @(posedge clk); #2;
    bus.cpu_memrq = 1'b1;
    rst_n = 1'b0;
    #1;
    reset_checks("arst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_arst_mem_rst_n", 32'(bus.mem_rst_n), 1);
    chk("post_arst_done", 32'(bus.done), 0);
    exp_q.delete();
    do_load(3, 1'b1, 50);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end
endmodule
